// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic IDLE_LEVEL_DEF = 1'b0;

  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Ready/valid word in, one bit per clock out on x_o with frame/done markers;
// a word accepted on the last-bit edge follows with no idle gap.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             frame_o,
  output logic             done_o
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               x_q, x_d;
  logic               frame_q, frame_d;
  logic               done_q, done_d;

  logic               last_bit;
  logic               accept;
  logic               first_bit;
  logic               next_bit;
  logic [WIDTH-1:0]   load_rem;
  logic [WIDTH-1:0]   shift_rem;

  assign last_bit = (state_q == SHIFT) && (cnt_q == '0);
  assign ready_o  = (state_q == IDLE) || last_bit;
  assign accept   = valid_i & ready_o;

  // The first bit goes straight to x_q on the accept edge, so the shift
  // register only ever holds the bits still to be sent.
  assign first_bit = MSB_FIRST ? data_i[WIDTH-1]  : data_i[0];
  assign load_rem  = MSB_FIRST ? (data_i << 1)    : (data_i >> 1);
  assign next_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shift_rem = MSB_FIRST ? (shreg_q << 1)   : (shreg_q >> 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    x_d     = x_q;
    frame_d = frame_q;
    done_d  = done_q;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = CNT_W'(WIDTH - 1);
      shreg_d = load_rem;
      x_d     = first_bit;
      frame_d = 1'b1;
      done_d  = 1'b0;
    end else if (state_q == SHIFT) begin
      if (cnt_q != '0) begin
        cnt_d   = cnt_q - CNT_W'(1);
        shreg_d = shift_rem;
        x_d     = next_bit;
        frame_d = 1'b1;
        done_d  = (cnt_q == CNT_W'(1));
      end else begin
        state_d = IDLE;
        shreg_d = '0;
        x_d     = IDLE_LEVEL;
        frame_d = 1'b0;
        done_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= IDLE_LEVEL;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  assign x_o     = x_q;
  assign frame_o = frame_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: 4-bit MSB-first and 8-bit LSB-first instances.
module tb_piso_serializer;

  logic       clk;
  logic       reset_n;
  logic [3:0] data4;
  logic       valid4;
  logic       ready4, x4, frame4, done4;
  logic [7:0] data8;
  logic       valid8;
  logic       ready8, x8, frame8, done8;
  logic [3:0] sr;

  int total = 0;
  int bad   = 0;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut4 (
    .clk(clk), .reset_n(reset_n), .data_i(data4), .valid_i(valid4),
    .ready_o(ready4), .x_o(x4), .frame_o(frame4), .done_o(done4)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut8 (
    .clk(clk), .reset_n(reset_n), .data_i(data8), .valid_i(valid8),
    .ready_o(ready8), .x_o(x8), .frame_o(frame8), .done_o(done8)
  );

  // Receive-side 4-bit left-shifting SIPO fed from the serial line.
  always_ff @(posedge clk) sr <= {sr[2:0], x4};

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] w4;
    logic [7:0] w8;
    clk     = 1'b0;
    reset_n = 1'b0;
    data4   = '0;
    valid4  = 1'b0;
    data8   = '0;
    valid8  = 1'b0;

    // reset state
    #1;
    chk1("rst_x", x4, 1'b0);
    chk1("rst_frame", frame4, 1'b0);
    chk1("rst_done", done4, 1'b0);
    chk1("rst_ready", ready4, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: idle with valid low
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("idle_ready", ready4, 1'b1);
      chk1("idle_frame", frame4, 1'b0);
      chk1("idle_x", x4, 1'b0);
    end

    // 2: single word 1011 MSB first
    w4 = 4'b1011;
    data4 = w4; valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("w1_x", x4, w4[3-i]);
      chk1("w1_frame", frame4, 1'b1);
      chk1("w1_done", done4, i == 3);
      chk1("w1_ready", ready4, i == 3);
      if (i < 3) step();
    end
    step();
    chk1("w1_end_frame", frame4, 1'b0);
    chk1("w1_end_x", x4, 1'b0);
    chk1("w1_end_done", done4, 1'b0);
    chk1("w1_end_ready", ready4, 1'b1);

    // 3: back-to-back 1011 then 0110 accepted on the last-bit edge
    w8 = 8'b1011_0110;
    data4 = 4'b1011; valid4 = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      chk1("b2b_x", x4, w8[7-i]);
      chk1("b2b_frame", frame4, 1'b1);
      chk1("b2b_done", done4, (i == 3) || (i == 7));
      valid4 = (i == 3);
      data4  = 4'b0110;
      if (i < 7) step();
    end
    step();
    chk1("b2b_end_frame", frame4, 1'b0);

    // 4: loopback into SIPO
    data4 = 4'b1011; valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    repeat (3) step();
    chk1("lb_done", done4, 1'b1);
    step();
    chk4("lb_sr", sr, 4'b1011);

    // 5: reset mid-word, then resume
    data4 = 4'b1111; valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    step();
    chk1("mid_x", x4, 1'b1);
    chk1("mid_frame", frame4, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk1("arst_x", x4, 1'b0);
    chk1("arst_frame", frame4, 1'b0);
    chk1("arst_done", done4, 1'b0);
    chk1("arst_ready", ready4, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    w4 = 4'b0001;
    data4 = w4; valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("post_x", x4, w4[3-i]);
      chk1("post_done", done4, i == 3);
      if (i < 3) step();
    end
    step();
    chk1("post_end_frame", frame4, 1'b0);

    // 6: 8-bit LSB first, valid toggled mid-word
    w8 = 8'hA5;
    data8 = w8; valid8 = 1'b1;
    step();
    valid8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk1("lsb_x", x8, w8[i]);
      chk1("lsb_frame", frame8, 1'b1);
      chk1("lsb_ready", ready8, i == 7);
      chk1("lsb_done", done8, i == 7);
      valid8 = (i == 2) || (i == 4);
      data8  = 8'hFF;
      if (i < 7) step();
    end
    step();
    chk1("lsb_end_frame", frame8, 1'b0);
    chk1("lsb_end_x", x8, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
